// File: rtl/sar_dac_stream_player_if.sv
// Bundle of the sample-stream handshake, playback controls and DAC-side outputs
// of the stream player. The player modport belongs to the DUT and the host modport to its driver.
interface sar_dac_stream_player_if #(
   parameter int unsigned NUM_BITS   = 4,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned RATE_W     = 8
);
   logic                          enable;
   logic [RATE_W-1:0]             sample_rate;
   logic [NUM_BITS-1:0]           s_data;
   logic                          s_valid;
   logic                          s_ready;
   logic [NUM_BITS-1:0]           dac_code;
   logic                          dac_update;
   logic                          underrun;
   logic [$clog2(FIFO_DEPTH):0]   fifo_level;

   modport player (
      input  enable, sample_rate, s_data, s_valid,
      output s_ready, dac_code, dac_update, underrun, fifo_level
   );

   modport host (
      output enable, sample_rate, s_data, s_valid,
      input  s_ready, dac_code, dac_update, underrun, fifo_level
   );
endinterface

// File: rtl/sar_dac_stream_player.sv
// Paced DAC playback: FIFO-buffered samples, with one code update every sample_rate+1 cycles.
// Define UNDERRUN_MIDSCALE_EN to drive midscale on underrun ticks; otherwise the code is held.
module sar_dac_stream_player #(
   parameter int unsigned NUM_BITS   = 4,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned RATE_W     = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   sar_dac_stream_player_if.player       bus
);
   localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
   localparam int unsigned LvlW = PtrW + 1;
   localparam logic [LvlW-1:0] LvlFull = LvlW'(FIFO_DEPTH);
`ifdef UNDERRUN_MIDSCALE_EN
   localparam logic [NUM_BITS-1:0] MidCode = NUM_BITS'(1) << (NUM_BITS - 1);
`endif

   logic [NUM_BITS-1:0] mem_q [FIFO_DEPTH];
   logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LvlW-1:0]     level_q, level_d;
   logic [RATE_W-1:0]   rate_cnt_q, rate_cnt_d;
   logic [NUM_BITS-1:0] dac_code_q, dac_code_d;
   logic                dac_update_q, dac_update_d;
   logic                underrun_q, underrun_d;
   logic                ready, push, pop, tick;

   // Ready comes only from the registered level, so a same-cycle pop never frees a slot.
   assign ready          = (level_q != LvlFull);
   assign bus.s_ready    = ready;
   assign bus.dac_code   = dac_code_q;
   assign bus.dac_update = dac_update_q;
   assign bus.underrun   = underrun_q;
   assign bus.fifo_level = level_q;

   always_comb begin
      tick         = bus.enable && (rate_cnt_q >= bus.sample_rate);
      push         = bus.s_valid && ready;
      pop          = tick && (level_q != '0);
      rate_cnt_d   = '0;
      if (bus.enable && !tick) begin
         rate_cnt_d = rate_cnt_q + RATE_W'(1);
      end
      wr_ptr_d     = wr_ptr_q + PtrW'(push);
      rd_ptr_d     = rd_ptr_q + PtrW'(pop);
      level_d      = level_q + LvlW'(push) - LvlW'(pop);
      dac_code_d   = dac_code_q;
      dac_update_d = 1'b0;
      underrun_d   = tick && !pop;
      if (pop) begin
         dac_code_d   = mem_q[rd_ptr_q];
         dac_update_d = 1'b1;
      end
`ifdef UNDERRUN_MIDSCALE_EN
      else if (tick) begin
         dac_code_d   = MidCode;
         dac_update_d = 1'b1;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         level_q      <= '0;
         rate_cnt_q   <= '0;
         dac_code_q   <= '0;
         dac_update_q <= 1'b0;
         underrun_q   <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         level_q      <= level_d;
         rate_cnt_q   <= rate_cnt_d;
         dac_code_q   <= dac_code_d;
         dac_update_q <= dac_update_d;
         underrun_q   <= underrun_d;
      end
   end

   // Storage needs no reset: the pointers and level define which entries are live.
   always_ff @(posedge clk) begin
      if (!rst && push) begin
         mem_q[wr_ptr_q] <= bus.s_data;
      end
   end
endmodule

// File: tb/tb_sar_dac_stream_player.sv
// Bench for sar_dac_stream_player: fixed vector table, directed corner sequences and
// randomized traffic, all checked against a queue-based playback model.
module tb_sar_dac_stream_player;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   sar_dac_stream_player_if #(.NUM_BITS(4), .FIFO_DEPTH(8), .RATE_W(8)) bus ();

   sar_dac_stream_player #(.NUM_BITS(4), .FIFO_DEPTH(8), .RATE_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

`ifdef UNDERRUN_MIDSCALE_EN
   localparam bit Midscale = 1'b1;
`else
   localparam bit Midscale = 1'b0;
`endif

   int checks = 0;
   int errors = 0;

   // Model state: buffered samples plus cycles elapsed since the last tick / enable.
   int q[$];
   int m_cnt  = 0;
   int m_code = 0;
   bit m_upd  = 1'b0;
   bit m_und  = 1'b0;

   typedef struct {
      bit       r;
      bit       en;
      int       rate;
      int       data;
      bit       valid;
      int       code;
      bit       upd;
      bit       und;
      int       lvl;
      bit       rdy;
   } vec_t;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_edge(input bit r, input bit e, input int rate, input int d, input bit v);
      bit rdy, tk;
      if (r) begin
         q.delete();
         m_cnt = 0; m_code = 0; m_upd = 1'b0; m_und = 1'b0;
      end else begin
         rdy   = (q.size() != 8);
         tk    = e && (m_cnt >= rate);
         m_cnt = (!e || tk) ? 0 : m_cnt + 1;
         m_upd = 1'b0;
         m_und = 1'b0;
         if (tk) begin
            if (q.size() > 0) begin
               m_code = q.pop_front();
               m_upd  = 1'b1;
            end else begin
               m_und = 1'b1;
               if (Midscale) begin
                  m_code = 8;
                  m_upd  = 1'b1;
               end
            end
         end
         if (v && rdy) q.push_back(d);
      end
   endtask

   // Applies inputs for one clock edge, advances the model, then compares 1 time unit after the edge.
   task automatic step(input bit r, input bit e, input int rate, input int d, input bit v);
      rst             = r;
      bus.enable      = e;
      bus.sample_rate = 8'(rate);
      bus.s_data      = 4'(d);
      bus.s_valid     = v;
      model_edge(r, e, rate, d, v);
      @(posedge clk);
      #1;
      chk("dac_code",   int'(bus.dac_code),   m_code);
      chk("dac_update", int'(bus.dac_update), int'(m_upd));
      chk("underrun",   int'(bus.underrun),   int'(m_und));
      chk("fifo_level", int'(bus.fifo_level), q.size());
      chk("s_ready",    int'(bus.s_ready),    int'(q.size() != 8));
   endtask

   vec_t vt[12];
   int   seen;

   initial begin
      rst = 1'b1; bus.enable = 1'b0; bus.sample_rate = '0; bus.s_data = '0; bus.s_valid = 1'b0;

      // rst en rate data valid | code upd und lvl rdy
      vt[0]  = '{1, 0, 1, 0, 0,  0, 0, 0, 0, 1};
      vt[1]  = '{0, 0, 1, 5, 1,  0, 0, 0, 1, 1};
      vt[2]  = '{0, 0, 1, 9, 1,  0, 0, 0, 2, 1};
      vt[3]  = '{0, 1, 1, 0, 0,  0, 0, 0, 2, 1};
      vt[4]  = '{0, 1, 1, 0, 0,  5, 1, 0, 1, 1};
      vt[5]  = '{0, 1, 1, 2, 1,  5, 0, 0, 2, 1};
      vt[6]  = '{0, 1, 1, 0, 0,  9, 1, 0, 1, 1};
      vt[7]  = '{0, 0, 1, 0, 0,  9, 0, 0, 1, 1};
      vt[8]  = '{0, 1, 0, 7, 1,  2, 1, 0, 1, 1};
      vt[9]  = '{0, 1, 0, 0, 0,  7, 1, 0, 0, 1};
      vt[10] = '{0, 0, 0, 3, 1,  7, 0, 0, 1, 1};
      vt[11] = '{1, 0, 0, 4, 1,  0, 0, 0, 0, 1};
      for (int i = 0; i < 12; i++) begin
         step(vt[i].r, vt[i].en, vt[i].rate, vt[i].data, vt[i].valid);
         chk($sformatf("vec%0d_code", i), int'(bus.dac_code),   vt[i].code);
         chk($sformatf("vec%0d_upd", i),  int'(bus.dac_update), int'(vt[i].upd));
         chk($sformatf("vec%0d_und", i),  int'(bus.underrun),   int'(vt[i].und));
         chk($sformatf("vec%0d_lvl", i),  int'(bus.fifo_level), vt[i].lvl);
         chk($sformatf("vec%0d_rdy", i),  int'(bus.s_ready),    int'(vt[i].rdy));
      end

      // Paced playback at rate 3: updates 4 cycles apart.
      step(1, 0, 3, 0, 0);
      step(0, 0, 3, 5, 1);
      step(0, 0, 3, 9, 1);
      step(0, 0, 3, 2, 1);
      for (int i = 0; i < 16; i++) step(0, 1, 3, 0, 0);

      // Fill while paused; ninth sample held off; then drain at full rate into underruns.
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 8; i++) step(0, 0, 0, i + 3, 1);
      step(0, 0, 0, 15, 1);
      chk("full_ready", int'(bus.s_ready), 0);
      chk("full_level", int'(bus.fifo_level), 8);
      for (int i = 0; i < 11; i++) step(0, 1, 0, 0, 0);
      chk("drain_underrun", int'(bus.underrun), 1);

      // Empty FIFO underrun while the last code is 9.
      step(0, 0, 0, 9, 1);
      step(0, 1, 0, 0, 0);
      chk("code9", int'(bus.dac_code), 9);
      step(0, 1, 0, 0, 0);
      chk("und_tick", int'(bus.underrun), 1);
      chk("und_code", int'(bus.dac_code), Midscale ? 8 : 9);

      // Full FIFO, continuous pops and pushes across pointer wrap.
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 8; i++) step(0, 0, 0, i, 1);
      for (int i = 0; i < 24; i++) step(0, 1, 0, (i + 8) % 16, 1);

      // Rate drop from 200 to 2 while the counter sits at 50.
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 50; i++) step(0, 1, 200, 0, 0);
      chk("rate_no_tick", int'(bus.underrun), 0);
      step(0, 1, 2, 0, 0);
      chk("rate_drop_tick", int'(bus.underrun), 1);
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         step(0, 1, 2, 0, 0);
         seen += int'(bus.underrun);
      end
      chk("rate_every3", seen, 2);

      // Reset mid-playback with 5 samples buffered.
      for (int i = 0; i < 5; i++) step(0, 0, 1, i + 1, 1);
      step(0, 1, 1, 0, 0);
      step(0, 1, 1, 0, 0);
      step(1, 1, 1, 0, 0);
      chk("rst_level", int'(bus.fifo_level), 0);
      chk("rst_code", int'(bus.dac_code), 0);
      chk("rst_upd", int'(bus.dac_update), 0);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
              ($urandom_range(0, 2) != 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
